// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the LC-3b I-cache and
// D-cache miss controllers. One transaction is in flight at a time; ties are
// broken round-robin against the last requester served. A done cycle follows
// every transaction so the served cache can drop its request before the
// next arbitration.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    // I-cache side
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    // D-cache side
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    // physical memory side
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;
    logic       w_next_grant;
    logic       w_i_pending;
    logic       w_d_pending;

    assign w_i_pending = i_read | i_write;
    assign w_d_pending = d_read | d_write;

    // Read lines go to both caches; only the matching resp qualifies them.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Next-state and next-grant selection; a tie goes to whoever was not served last.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_i_pending && w_d_pending) begin
                    if (r_last_grant == GRANT_I) begin
                        w_next_state = ST_SERVE_D;
                        w_next_grant = GRANT_D;
                    end else begin
                        w_next_state = ST_SERVE_I;
                        w_next_grant = GRANT_I;
                    end
                end else if (w_i_pending) begin
                    w_next_state = ST_SERVE_I;
                    w_next_grant = GRANT_I;
                end else if (w_d_pending) begin
                    w_next_state = ST_SERVE_D;
                    w_next_grant = GRANT_D;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                if (pmem_resp) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                if (pmem_resp) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SERVE_D;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State and last-grant registers; reset makes the first tie go to D.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_grant;
        end
    end

    // Memory-port mux and response routing; a write request wins over a read.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            ST_SERVE_I: begin
                pmem_write   = i_write;
                pmem_read    = i_read & ~i_write;
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                i_resp       = pmem_resp;
            end
            ST_SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays memory, pushes the
// expected (requester, line) onto a scoreboard when it answers, and a
// monitor pops and compares on every i_resp/d_resp pulse.
module tb_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         i_read, i_write, d_read, d_write;
    logic [15:0]  i_address, d_address;
    logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic         i_resp, d_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    typedef struct {
        logic         who;   // 0 = I, 1 = D
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic WHO_I = 1'b0;
    localparam logic WHO_D = 1'b1;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every resp pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (i_resp && d_resp) begin
            check_val("resp_both", 128'd1, 128'd0);
        end
        if (i_resp || d_resp) begin
            if (sb_q.size() == 0) begin
                check_val("resp_unexpected", {127'd0, d_resp}, 128'hDEAD);
            end else begin
                e = sb_q.pop_front();
                check_val("resp_who", {127'd0, d_resp}, {127'd0, e.who});
                check_val("resp_data", d_resp ? d_rdata : i_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        {i_read, i_write, d_read, d_write} = 4'b0000;
        pmem_resp = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Called just after a posedge; returns cycles until the strobe is seen
    // (1 = visible in the next cycle), or -1 on timeout.
    task automatic wait_strobe(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                lat = c - 1;
                break;
            end
        end
        if (lat < 0) begin
            check_val("strobe_timeout", 128'd0, 128'd1);
        end
    endtask

    // Called at the negedge of the first serve cycle; memory answers lat
    // cycles later. Returns just after the posedge that ends the resp cycle.
    task automatic serve(input int lat, input logic [127:0] data, input logic who,
                         input logic [15:0] addr, input logic is_wr, input logic [127:0] wd);
        exp_t e;
        for (int k = 0; k < lat; k++) begin
            check_val("serve_addr", {112'd0, pmem_address}, {112'd0, addr});
            check_val("serve_wr", {127'd0, pmem_write}, {127'd0, is_wr});
            check_val("serve_rd", {127'd0, pmem_read}, {127'd0, ~is_wr});
            if (is_wr) begin
                check_val("serve_wdata", pmem_wdata, wd);
            end
            tick();
            if (k == lat - 1) begin
                e.who  = who;
                e.data = data;
                sb_q.push_back(e);
                pmem_resp  = 1'b1;
                pmem_rdata = data;
            end
            @(negedge clk);
        end
        check_val("resp_same_cycle", {127'd0, (who ? d_resp : i_resp)}, 128'd1);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = ~data;
    endtask

    initial begin
        int lat;
        logic [127:0] a5_line;
        logic [127:0] d_line;
        a5_line = {16{8'hA5}};
        d_line  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        reset = 1'b0;
        {i_read, i_write, d_read, d_write} = 4'b0000;
        i_address = 16'd0; d_address = 16'd0;
        i_wdata = 128'd0; d_wdata = 128'd0;
        pmem_resp = 1'b0; pmem_rdata = 128'h5A5A;

        // Reset state: all outputs low.
        do_reset();
        @(negedge clk);
        check_val("rst_outputs", {124'd0, pmem_read, pmem_write, i_resp, d_resp}, 128'd0);
        check_val("rst_addr", {112'd0, pmem_address}, 128'd0);
        check_val("rst_wdata", pmem_wdata, 128'd0);

        // Single I read, memory answers 3 cycles after the strobe.
        tick();
        i_read = 1'b1; i_address = 16'h1230;
        wait_strobe(lat);
        check_val("i_rd_latency", lat, 128'd1);
        serve(3, a5_line, WHO_I, 16'h1230, 1'b0, 128'd0);
        i_read = 1'b0;
        @(negedge clk);
        check_val("i_done_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);

        // D write, memory answers 2 cycles after the strobe.
        tick();
        d_write = 1'b1; d_address = 16'h4440; d_wdata = d_line;
        wait_strobe(lat);
        check_val("d_wr_latency", lat, 128'd1);
        serve(2, 128'h77, WHO_D, 16'h4440, 1'b1, d_line);
        d_write = 1'b0;
        @(negedge clk);
        check_val("d_done_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);

        // Simultaneous reads right after reset: D first, then I at M+3.
        do_reset();
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        wait_strobe(lat);
        check_val("tie_first_addr", {112'd0, pmem_address}, {112'd0, 16'h2222});
        serve(1, 128'hD1, WHO_D, 16'h2222, 1'b0, 128'd0);
        d_read = 1'b0;
        wait_strobe(lat);
        check_val("tie_gap", lat, 128'd2);
        check_val("tie_second_addr", {112'd0, pmem_address}, {112'd0, 16'h1111});
        serve(2, 128'h11, WHO_I, 16'h1111, 1'b0, 128'd0);
        i_read = 1'b0;

        // Both held pending for six grants: D,I,D,I,D,I.
        do_reset();
        i_read = 1'b1; i_address = 16'h3000;
        d_read = 1'b1; d_address = 16'h4000;
        for (int k = 0; k < 6; k++) begin
            logic who;
            logic [15:0] addr;
            who  = (k % 2 == 0) ? WHO_D : WHO_I;
            addr = who ? 16'h4000 : 16'h3000;
            wait_strobe(lat);
            check_val("alt_spacing", lat, (k == 0) ? 128'd1 : 128'd2);
            check_val("alt_grant_addr", {112'd0, pmem_address}, {112'd0, addr});
            serve(1, 128'hC00 + 128'(k), who, addr, 1'b0, 128'd0);
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // Reset in the second serve cycle of an I read; resp arrives a cycle later.
        do_reset();
        i_read = 1'b1; i_address = 16'h5550;
        wait_strobe(lat);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_read = 1'b0;
        pmem_resp = 1'b1;
        pmem_rdata = 128'hBAD;
        @(negedge clk);
        check_val("abort_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
        check_val("abort_i_resp", {127'd0, i_resp}, 128'd0);
        tick();
        pmem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h6660;
        d_read = 1'b1; d_address = 16'h7770;
        wait_strobe(lat);
        check_val("abort_tie_lat", lat, 128'd1);
        check_val("abort_tie_addr", {112'd0, pmem_address}, {112'd0, 16'h7770});
        serve(1, 128'hD2, WHO_D, 16'h7770, 1'b0, 128'd0);
        d_read = 1'b0;
        wait_strobe(lat);
        serve(1, 128'hE2, WHO_I, 16'h6660, 1'b0, 128'd0);
        i_read = 1'b0;
        tick();

        // Stray pmem_resp while idle: nothing forwarded, still idle.
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        check_val("stray_resp", {126'd0, i_resp, d_resp}, 128'd0);
        tick();
        pmem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h8880;
        wait_strobe(lat);
        check_val("stray_then_lat", lat, 128'd1);
        serve(1, 128'hF3, WHO_I, 16'h8880, 1'b0, 128'd0);
        i_read = 1'b0;
        tick();
        tick();

        check_val("sb_leftover", sb_q.size(), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one physical-memory port between the instruction-side and data-side caches of the LC-3b pipeline. It accepts cache-line read/write requests from both caches, grants one transaction at a time with round-robin tie-breaking, and forwards it to physical memory. It routes the memory response back to the granted requester only. It sits between the I-cache/D-cache miss controllers and the physical memory model.

## Interface
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- i_read  input  1  I-cache line read request; held until i_resp
- i_write  input  1  I-cache line write request; held until i_resp
- i_address  input  ADDR_WIDTH  I-side line address; stable while request high
- i_wdata  input  LINE_WIDTH  I-side write line
- i_rdata  output  LINE_WIDTH  read line to I-cache; valid when i_resp=1
- i_resp  output  1  I-side transaction complete, single cycle
- d_read, d_write, d_address, d_wdata, d_rdata, d_resp: same as i_* for the D-cache
- pmem_read  output  1  physical memory read strobe
- pmem_write  output  1  physical memory write strobe
- pmem_address  output  ADDR_WIDTH  physical memory address
- pmem_wdata  output  LINE_WIDTH  physical memory write line
- pmem_rdata  input  LINE_WIDTH  physical memory read line
- pmem_resp  input  1  physical memory completion, single cycle

## Operation
- Registered FSM with states idle, serve_i, serve_d, done. A 1-bit last_grant register holds I or D.
- A requester is pending when its read or write is high. Read and write both high: treated as write.
- idle: if only I is pending, go to serve_i. If only D is pending, go to serve_d. If both are pending, grant the requester that is not last_grant. If neither is pending, stay in idle.
- On entering serve_x, last_grant <= x.
- serve_x:
  - pmem_read/pmem_write = x_read/x_write, with the write-wins rule applied.
  - pmem_address and pmem_wdata = x_address and x_wdata.
  - The other requester's signals are ignored and its resp stays 0.
- serve_x with pmem_resp=1: x_resp=1 in the same cycle, then go to done. Otherwise stay in serve_x; there is no timeout.
- done: all pmem strobes 0 and both resp 0. Always go to idle. This turnaround cycle lets the served cache drop its request before re-arbitration.
- i_rdata and d_rdata are both driven continuously from pmem_rdata. Only the matching resp qualifies them.
- In idle and done: pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
- pmem_resp in idle or done is ignored and is not forwarded.
- Request dropped mid-serve (protocol violation): strobes follow the inputs and go low. The FSM stays in serve_x until pmem_resp.

## Timing
- Reset (synchronous, applied at an edge): state=idle, last_grant=I.
  - Every output is 0 from the cycle after the reset edge, except the rdata pass-throughs.
  - The first tie after reset goes to D.
- Reset mid-transaction: FSM returns to idle at that edge and strobes are 0 the next cycle. A pmem_resp for the aborted access is not forwarded.
- Request first visible high in cycle N while idle: strobe asserted from cycle N+1, the first serve cycle.
- pmem_resp in cycle M: x_resp=1 in cycle M (combinational), done in M+1, idle in M+2.
- If the other requester is pending in M+2, its strobe rises in M+3.
- Minimum spacing between successive pmem transactions: 2 idle-strobe cycles (done, idle).
- Request-to-resp latency = 1 + memory latency. Each x_resp is exactly one cycle per transaction.
- Both requesters continuously pending: grants strictly alternate I/D, so neither requester can starve.

## Test plan
- Reset then single I read, i_address=16'h1230, memory responds 3 cycles after strobe with rdata=128'hA5..A5:
  - pmem_read rises 1 cycle after request, with pmem_address=16'h1230.
  - i_resp is a single pulse with i_rdata=128'hA5..A5.
  - d_resp stays 0 throughout.
- D write, d_address=16'h4440, d_wdata=128'h0123..:
  - pmem_write=1, pmem_read=0, pmem_wdata matches for the whole serve phase.
  - d_resp pulses once.
  - Strobes are 0 during done.
- Simultaneous I and D reads right after reset:
  - D is served first.
  - I is granted at M+2 and its strobe rises at M+3.
  - Second pmem_address = i_address.
- Both held pending for 6 transactions: grant order is D,I,D,I,D,I and each resp pulses exactly once per grant.
- Reset asserted in the second serve cycle of an I read, with pmem_resp arriving 1 cycle later:
  - Strobes are 0 after the reset edge.
  - i_resp stays 0.
  - The FSM is in idle and the next tie goes to D.
- Stray pmem_resp pulse while idle: no i_resp or d_resp, and the state stays idle.
